node_loader: RTL

NODE_LOADER -- requirements
Module: node_loader

---
 rtl/node_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/node_loader.sv
// rtl/node_loader.sv - byte-stream loader that packs operands, fires a node and returns its result
// Optional feature macro: NODE_LOADER_BIAS_EN (33-byte jobs with a loaded bias byte; otherwise 32 bytes and bias = 0)
module node_loader #(
  parameter int unsigned RES_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:7]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [0:127] inA,
  output logic [0:127] inB,
  output logic [0:7]   bias,
  output logic         rdy,
  input  logic [0:7]   res,
  output logic [0:7]   m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [3:0] LAT = 4'(RES_LAT);

`ifdef NODE_LOADER_BIAS_EN
  localparam logic [5:0] LAST_IDX = 6'd32;
`else
  localparam logic [5:0] LAST_IDX = 6'd31;
`endif

  logic [1:0]   state_q, state_d;
  logic [5:0]   idx_q, idx_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [0:127] in_a_q, in_a_d;
  logic [0:127] in_b_q, in_b_d;
  logic [0:7]   m_data_q, m_data_d;
  logic [6:0]   lane_base;

  // byte lane inside the 128-bit operand selected by the low four index bits
  assign lane_base = {idx_q[3:0], 3'b000};

`ifdef NODE_LOADER_BIAS_EN
  logic [0:7] bias_q, bias_d;
  assign bias = bias_q;
`else
  assign bias = 8'h00;
`endif

  assign s_ready = (state_q == ST_LOAD);
  assign rdy     = (state_q == ST_FIRE);
  assign m_valid = (state_q == ST_OUT);
  assign inA     = in_a_q;
  assign inB     = in_b_q;
  assign m_data  = m_data_q;

  // next-state: byte packing, fire pulse, latency count and result handshake
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    in_a_d   = in_a_q;
    in_b_d   = in_b_q;
    m_data_d = m_data_q;
`ifdef NODE_LOADER_BIAS_EN
    bias_d   = bias_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          if (!idx_q[5]) begin
            if (!idx_q[4]) begin
              in_a_d[lane_base +: 8] = s_data;
            end else begin
              in_b_d[lane_base +: 8] = s_data;
            end
          end
`ifdef NODE_LOADER_BIAS_EN
          else begin
            bias_d = s_data;
          end
`endif
          if (idx_q == LAST_IDX) begin
            idx_d   = 6'd0;
            state_d = ST_FIRE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_FIRE: begin
        // the rdy cycle itself counts as cycle 0, so the first wait cycle is 1
        cnt_d   = 4'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == LAT) begin
          m_data_d = res;
          cnt_d    = 4'd0;
          state_d  = ST_OUT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        if (m_ready) begin
          state_d = ST_LOAD;
        end
      end
    endcase
  end

  // state registers with synchronous reset that discards any job in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      idx_q    <= 6'd0;
      cnt_q    <= 4'd0;
      in_a_q   <= '0;
      in_b_q   <= '0;
      m_data_q <= '0;
`ifdef NODE_LOADER_BIAS_EN
      bias_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      in_a_q   <= in_a_d;
      in_b_q   <= in_b_d;
      m_data_q <= m_data_d;
`ifdef NODE_LOADER_BIAS_EN
      bias_q   <= bias_d;
`endif
    end
  end

endmodule
